// File: rtl/am2910_pkg.sv
// Shared constants for the Am2910-compatible microprogram sequencer.
// Opcode values match the original part's instruction table.
package am2910_pkg;

  localparam int ADDR_W      = 12;
  localparam int STACK_DEPTH = 5;
  localparam int SP_W        = 3;

  localparam logic [3:0] OP_JZ   = 4'h0;
  localparam logic [3:0] OP_CJS  = 4'h1;
  localparam logic [3:0] OP_JMAP = 4'h2;
  localparam logic [3:0] OP_CJP  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_JSRP = 4'h5;
  localparam logic [3:0] OP_CJV  = 4'h6;
  localparam logic [3:0] OP_JRP  = 4'h7;
  localparam logic [3:0] OP_RFCT = 4'h8;
  localparam logic [3:0] OP_RPCT = 4'h9;
  localparam logic [3:0] OP_CRTN = 4'hA;
  localparam logic [3:0] OP_CJPP = 4'hB;
  localparam logic [3:0] OP_LDCT = 4'hC;
  localparam logic [3:0] OP_LOOP = 4'hD;
  localparam logic [3:0] OP_CONT = 4'hE;
  localparam logic [3:0] OP_TWB  = 4'hF;

endpackage

// File: rtl/am2910_stack.sv
// Five-entry return-address LIFO with synchronous push/pop/clear.
// Pushing into a full stack replaces the top entry rather than growing.
module am2910_stack
  import am2910_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] tos,
  output logic              full
);

  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];

  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      if (sp_q == SP_W'(STACK_DEPTH)) begin
        mem_d[STACK_DEPTH-1] = din;
      end else begin
        mem_d[sp_q] = din;
        sp_d        = sp_q + SP_W'(1);
      end
    end else if (pop && (sp_q != '0)) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

  // An empty stack reads as address zero.
  assign tos  = (sp_q == '0) ? '0 : mem_q[sp_q - SP_W'(1)];
  assign full = (sp_q == SP_W'(STACK_DEPTH));

endmodule

// File: rtl/am2910.sv
// Am2910-compatible 12-bit microprogram sequencer: next-address mux,
// microPC incrementer, loop counter R, source-enable decode and Y tristate.
module am2910
  import am2910_pkg::*;
(
  input  logic              CP,
  input  logic              RESET,
  input  logic [3:0]        I,
  input  logic [ADDR_W-1:0] D,
  input  logic              CC,
  input  logic              CCEN,
  input  logic              RLD,
  input  logic              CI,
  input  logic              OE,
  output logic              FULL,
  output logic              PL,
  output logic              MAP,
  output logic              VECT,
  output logic [ADDR_W-1:0] Y
);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] y_int, tos;
  logic              pass, rz;
  logic              push, pop, clear, stack_full;
  logic              pl_n, map_n, vect_n;

  assign pass = CCEN | ~CC;
  assign rz   = (r_q == '0);

  always_comb begin
    y_int  = upc_q;
    r_d    = r_q;
    push   = 1'b0;
    pop    = 1'b0;
    clear  = 1'b0;
    pl_n   = 1'b0;
    map_n  = 1'b1;
    vect_n = 1'b1;
    case (I)
      OP_JZ:   begin y_int = '0; clear = 1'b1; end
      OP_CJS:  begin if (pass) begin y_int = D; push = 1'b1; end end
      OP_JMAP: begin y_int = D; pl_n = 1'b1; map_n = 1'b0; end
      OP_CJP:  begin if (pass) y_int = D; end
      OP_PUSH: begin push = 1'b1; if (pass) r_d = D; end
      OP_JSRP: begin y_int = pass ? D : r_q; push = 1'b1; end
      OP_CJV:  begin if (pass) y_int = D; pl_n = 1'b1; vect_n = 1'b0; end
      OP_JRP:  begin y_int = pass ? D : r_q; end
      OP_RFCT: begin
        if (!rz) begin y_int = tos; r_d = r_q - ADDR_W'(1); end
        else pop = 1'b1;
      end
      OP_RPCT: begin if (!rz) begin y_int = D; r_d = r_q - ADDR_W'(1); end end
      OP_CRTN: begin if (pass) begin y_int = tos; pop = 1'b1; end end
      OP_CJPP: begin if (pass) begin y_int = D; pop = 1'b1; end end
      OP_LDCT: begin r_d = D; end
      OP_LOOP: begin if (pass) pop = 1'b1; else y_int = tos; end
      OP_CONT: begin end
      OP_TWB: begin
        if (pass) pop = 1'b1;
        else if (!rz) begin y_int = tos; r_d = r_q - ADDR_W'(1); end
        else begin y_int = D; pop = 1'b1; end
      end
      default: begin end
    endcase
    // An explicit counter load wins over whatever the instruction did to R.
    if (!RLD) r_d = D;
  end

  assign upc_d = y_int + {{(ADDR_W-1){1'b0}}, CI};

  always_ff @(posedge CP or posedge RESET) begin
    if (RESET) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  am2910_stack u_stack (
    .clk   (CP),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (upc_q),
    .tos   (tos),
    .full  (stack_full)
  );

  assign FULL = ~stack_full;
  assign PL   = pl_n;
  assign MAP  = map_n;
  assign VECT = vect_n;
  assign Y    = OE ? {ADDR_W{1'bz}} : y_int;

endmodule

// File: tb/tb_am2910.sv
// Scoreboard bench for am2910: expected Y/FULL/source enables are queued
// as each instruction is driven and compared before the clock edge.
module tb_am2910;

  localparam logic [2:0] SRC_PL   = 3'b011;
  localparam logic [2:0] SRC_MAP  = 3'b101;
  localparam logic [2:0] SRC_VECT = 3'b110;

  typedef struct {
    string       tag;
    logic [11:0] y;
    logic        oe;
    logic        full;
    logic [2:0]  src;
  } exp_t;

  logic        cp, reset, cc, ccen, rld, ci, oe;
  logic [3:0]  i;
  logic [11:0] d;
  logic        full, pl, map, vect;
  wire  [11:0] y;

  exp_t exp_q[$];
  int   check_count = 0;
  int   error_count = 0;

  am2910 dut (
    .CP(cp), .RESET(reset), .I(i), .D(d), .CC(cc), .CCEN(ccen), .RLD(rld),
    .CI(ci), .OE(oe), .FULL(full), .PL(pl), .MAP(map), .VECT(vect), .Y(y)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compareOutputs();
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      if (e.oe) checkOutput({e.tag, "_hiz"}, {31'd0, (y !== e.y)}, 32'd1);
      else      checkOutput({e.tag, "_y"}, {20'd0, y}, {20'd0, e.y});
      checkOutput({e.tag, "_full"}, {31'd0, full}, {31'd0, e.full});
      checkOutput({e.tag, "_src"}, {29'd0, pl, map, vect}, {29'd0, e.src});
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] ii, input logic [11:0] dd,
                               input logic ccv, input logic ccenv, input logic rldv,
                               input logic civ, input logic oev, input logic [11:0] ey,
                               input logic efull, input logic [2:0] esrc);
    exp_t e;
    i = ii; d = dd; cc = ccv; ccen = ccenv; rld = rldv; ci = civ; oe = oev;
    e.tag = tag; e.y = ey; e.oe = oev; e.full = efull; e.src = esrc;
    exp_q.push_back(e);
    #2;
    compareOutputs();
    @(posedge cp);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] ii, input logic [11:0] dd,
                      input logic ccv, input logic [11:0] ey, input logic efull,
                      input logic [2:0] esrc);
    applyStimulus(tag, ii, dd, ccv, 1'b0, 1'b1, 1'b1, 1'b0, ey, efull, esrc);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; i = 4'hE; d = '0; cc = 1'b1; ccen = 1'b0; rld = 1'b1; ci = 1'b1; oe = 1'b0;
    #12 reset = 1'b0;

    step("rst_y", 4'hE, 12'h000, 1'b1, 12'h000, 1'b1, SRC_PL);
    step("cnt1",  4'hE, 12'h000, 1'b1, 12'h001, 1'b1, SRC_PL);
    step("push_r",   4'h4, 12'h002, 1'b0, 12'h002, 1'b1, SRC_PL);
    step("rfct_a",   4'h8, 12'h000, 1'b1, 12'h002, 1'b1, SRC_PL);
    step("rfct_b",   4'h8, 12'h000, 1'b1, 12'h002, 1'b1, SRC_PL);
    step("rfct_end", 4'h8, 12'h000, 1'b1, 12'h003, 1'b1, SRC_PL);
    step("empty_f",  4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);

    step("cjs_pass",   4'h1, 12'h100, 1'b0, 12'h100, 1'b1, SRC_PL);
    step("cont",       4'hE, 12'h000, 1'b1, 12'h101, 1'b1, SRC_PL);
    step("crtn",       4'hA, 12'h000, 1'b0, 12'h001, 1'b1, SRC_PL);
    step("crtn_empty", 4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);
    step("cjp_fail",   4'h3, 12'h0AB, 1'b1, 12'h001, 1'b1, SRC_PL);

    for (int k = 0; k < 6; k++)
      step("push_fill", 4'h4, 12'h000, 1'b1, 12'(2 + k), (k < 5) ? 1'b1 : 1'b0, SRC_PL);
    step("full_flag", 4'hE, 12'h000, 1'b1, 12'h008, 1'b0, SRC_PL);
    step("ovr_top",   4'hA, 12'h000, 1'b0, 12'h007, 1'b0, SRC_PL);
    step("pop_next",  4'hA, 12'h000, 1'b0, 12'h005, 1'b1, SRC_PL);
    step("jz",        4'h0, 12'h555, 1'b1, 12'h000, 1'b1, SRC_PL);
    step("jz_clear",  4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);

    step("jmap",     4'h2, 12'h2A5, 1'b1, 12'h2A5, 1'b1, SRC_MAP);
    step("cjv_pass", 4'h6, 12'h155, 1'b0, 12'h155, 1'b1, SRC_VECT);
    step("cjv_fail", 4'h6, 12'h155, 1'b1, 12'h156, 1'b1, SRC_VECT);
    applyStimulus("oe", 4'h3, 12'h3C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h3C3, 1'b1, SRC_PL);
    applyStimulus("ccen_pass", 4'h3, 12'h0F0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h0F0, 1'b1, SRC_PL);
    step("cjp_fail2", 4'h3, 12'h0F0, 1'b1, 12'h0F1, 1'b1, SRC_PL);
    applyStimulus("ci0", 4'hE, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0F2, 1'b1, SRC_PL);
    step("ci1", 4'hE, 12'h000, 1'b1, 12'h0F2, 1'b1, SRC_PL);

    step("ldct",     4'hC, 12'h003, 1'b1, 12'h0F3, 1'b1, SRC_PL);
    step("jrp_r",    4'h7, 12'h050, 1'b1, 12'h003, 1'b1, SRC_PL);
    step("jrp_d",    4'h7, 12'h050, 1'b0, 12'h050, 1'b1, SRC_PL);
    step("jsrp_r",   4'h5, 12'h060, 1'b1, 12'h003, 1'b1, SRC_PL);
    step("rtn_jsrp", 4'hA, 12'h000, 1'b0, 12'h051, 1'b1, SRC_PL);

    step("push2",    4'h4, 12'h000, 1'b1, 12'h052, 1'b1, SRC_PL);
    step("rfct_dec", 4'h8, 12'h000, 1'b1, 12'h052, 1'b1, SRC_PL);
    applyStimulus("rld_ovr", 4'h8, 12'h005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h052, 1'b1, SRC_PL);
    for (int k = 0; k < 5; k++)
      step("rpct", 4'h9, 12'h200, 1'b1, 12'h200, 1'b1, SRC_PL);
    step("rpct_end", 4'h9, 12'h200, 1'b1, 12'h201, 1'b1, SRC_PL);

    step("cjpp_fail", 4'hB, 12'h300, 1'b1, 12'h202, 1'b1, SRC_PL);
    step("cjpp_pass", 4'hB, 12'h300, 1'b0, 12'h300, 1'b1, SRC_PL);
    step("push3",     4'h4, 12'h000, 1'b1, 12'h301, 1'b1, SRC_PL);
    step("loop_fail", 4'hD, 12'h000, 1'b1, 12'h301, 1'b1, SRC_PL);
    step("loop_pass", 4'hD, 12'h000, 1'b0, 12'h302, 1'b1, SRC_PL);

    step("push_r1",    4'h4, 12'h001, 1'b0, 12'h303, 1'b1, SRC_PL);
    step("twb_dec",    4'hF, 12'h000, 1'b1, 12'h303, 1'b1, SRC_PL);
    step("twb_rz",     4'hF, 12'h3AA, 1'b1, 12'h3AA, 1'b1, SRC_PL);
    step("twb_empty",  4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);
    step("push4",      4'h4, 12'h000, 1'b1, 12'h001, 1'b1, SRC_PL);
    step("twb_pass",   4'hF, 12'h000, 1'b0, 12'h002, 1'b1, SRC_PL);
    step("twb_popped", 4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);

    step("push_r4",  4'h4, 12'h004, 1'b0, 12'h001, 1'b1, SRC_PL);
    step("rfct_mid", 4'h8, 12'h000, 1'b1, 12'h001, 1'b1, SRC_PL);

    // Reset asserted between clock edges must take effect immediately.
    i = 4'hE; d = '0; cc = 1'b1;
    reset = 1'b1;
    e.tag = "async_rst"; e.y = 12'h000; e.oe = 1'b0; e.full = 1'b1; e.src = SRC_PL;
    exp_q.push_back(e);
    #1;
    compareOutputs();
    #1 reset = 1'b0;
    @(posedge cp);
    #1;
    step("post_rst_f", 4'hA, 12'h000, 1'b0, 12'h000, 1'b1, SRC_PL);
    step("post_rst_r", 4'h9, 12'h123, 1'b1, 12'h001, 1'b1, SRC_PL);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
